// File: rtl/alu_pkg.sv
// Opcode set, controller state encoding and opcode legality check for the
// shared-ALU controller.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_NOP = 6'b111111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        RESP   = ST_RESP
    } state_e;

    function automatic logic is_legal_op(input logic [5:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// ALU that evaluates only when its opcode changes; otherwise it presents the
// result, zero and carry of the last evaluation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic [5:0]            op_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic [WORD_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  carry_o
);

    localparam int SHW = $clog2(WORD_WIDTH);

    logic [5:0]            last_op_q;
    logic [WORD_WIDTH-1:0] res_q;
    logic                  zero_q;
    logic                  carry_q;
    logic [WORD_WIDTH-1:0] res_c;
    logic                  carry_c;
    logic                  eval;

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        case (op_i)
            OP_ADD:  {carry_c, res_c} = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  res_c = a_i - b_i;
            OP_AND:  res_c = a_i & b_i;
            OP_OR:   res_c = a_i | b_i;
            OP_XOR:  res_c = a_i ^ b_i;
            OP_NOR:  res_c = ~(a_i | b_i);
            OP_SRA:  res_c = $signed(a_i) >>> b_i[SHW-1:0];
            OP_SRL:  res_c = a_i >> b_i[SHW-1:0];
            default: res_c = '0;
        endcase
    end

    assign eval     = (op_i != last_op_q);
    assign result_o = eval ? res_c : res_q;
    assign zero_o   = eval ? (res_c == '0) : zero_q;
    assign carry_o  = eval ? carry_c : carry_q;

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            last_op_q <= OP_NOP;
            res_q     <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            last_op_q <= op_i;
            res_q     <= result_o;
            zero_q    <= zero_o;
            carry_q   <= carry_o;
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the pointer's requester wins when valid,
// otherwise the other requester. Purely combinational.
module rr_arb2 (
    input  logic       ptr_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (ptr_i == 1'b0) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin accept, hold operands
// for HOLD_CYCLES, then present a registered response with valid/ready.
//   state  | meaning
//   IDLE   | arbitrating, req_ready asserted for the granted requester
//   SETTLE | ALU inputs driven, counting down to capture
//   RESP   | response held on rsp_* until consumer handshake
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r0_req_valid,
    output logic                  r0_req_ready,
    input  logic [5:0]            r0_opcode,
    input  logic [WORD_WIDTH-1:0] r0_a,
    input  logic [WORD_WIDTH-1:0] r0_b,
    input  logic                  r1_req_valid,
    output logic                  r1_req_ready,
    input  logic [5:0]            r1_opcode,
    input  logic [WORD_WIDTH-1:0] r1_a,
    input  logic [WORD_WIDTH-1:0] r1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [WORD_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_carry,
    output logic                  rsp_illegal,
    output logic                  busy
);

    localparam logic [3:0] HOLD_CNT = 4'(HOLD_CYCLES);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [5:0]            op_q, op_d;
    logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  id_q, id_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d, carry_q, carry_d, ill_q, ill_d;

    logic [1:0]            gnt;
    logic [5:0]            sel_op;
    logic [WORD_WIDTH-1:0] sel_a, sel_b;
    logic [WORD_WIDTH-1:0] alu_res;
    logic                  alu_zero, alu_carry;

    rr_arb2 u_arb (
        .ptr_i (ptr_q),
        .req_i ({r1_req_valid, r0_req_valid}),
        .gnt_o (gnt)
    );

    alu_core #(.WORD_WIDTH(WORD_WIDTH)) u_alu (
        .clk       (clk),
        .reset_n_i (reset_n),
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .result_o  (alu_res),
        .zero_o    (alu_zero),
        .carry_o   (alu_carry)
    );

    assign sel_op = gnt[1] ? r1_opcode : r0_opcode;
    assign sel_a  = gnt[1] ? r1_a : r0_a;
    assign sel_b  = gnt[1] ? r1_b : r0_b;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        ill_d        = ill_q;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                r0_req_ready = gnt[0];
                r1_req_ready = gnt[1];
                if (|gnt) begin
                    id_d = gnt[1];
                    if (is_legal_op(sel_op)) begin
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cnt_d   = HOLD_CNT;
                        state_d = SETTLE;
                    end else begin
                        // Illegal codes never reach the ALU; drive stays at NOP.
                        res_d   = '0;
                        zero_d  = 1'b0;
                        carry_d = 1'b0;
                        ill_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = alu_res;
                    zero_d  = alu_zero;
                    carry_d = alu_carry & (op_q == OP_ADD);
                    ill_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ptr_d   = ~id_q;
                    op_d    = OP_NOP;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= 4'd0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ill_q   <= ill_d;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;
    assign rsp_carry   = carry_q;
    assign rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and random stimulus for alu_share_ctrl, checked every cycle against
// a transaction-level model of arbitration, latency and ALU arithmetic.
module tb_alu_share_ctrl;

    localparam int W    = 32;
    localparam int HOLD = 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic         r0_req_ready, r1_req_ready;
    logic [5:0]   r0_opcode = 6'h3F, r1_opcode = 6'h3F;
    logic [W-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_carry, rsp_illegal, busy;

    int n_chk = 0;
    int n_err = 0;

    alu_share_ctrl #(.WORD_WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .r0_req_valid (r0_req_valid),
        .r0_req_ready (r0_req_ready),
        .r0_opcode    (r0_opcode),
        .r0_a         (r0_a),
        .r0_b         (r0_b),
        .r1_req_valid (r1_req_valid),
        .r1_req_ready (r1_req_ready),
        .r1_opcode    (r1_opcode),
        .r1_a         (r1_a),
        .r1_b         (r1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_illegal  (rsp_illegal),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference ALU: plain arithmetic on the opcode table.
    function automatic void model_alu(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic z, output logic c,
                                      output logic ill);
        logic [W:0] s;
        r = '0; c = 1'b0; ill = 1'b0;
        case (op)
            6'b100000: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            6'b100010: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000011: r = $signed(a) >>> b[4:0];
            6'b000010: r = a >> b[4:0];
            default:   ill = 1'b1;
        endcase
        z = ill ? 1'b0 : (r == '0);
    endfunction

    // Model state: outstanding op, cycles until its response shows, last served id.
    logic         m_busy = 1'b0;
    int           m_rem = 0;
    logic         m_last = 1'b1;
    logic         m_id = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_zero = 1'b0, m_carry = 1'b0, m_ill = 1'b0;
    logic         acc0 = 1'b0, acc1 = 1'b0;
    logic         log_id[$];
    logic [W-1:0] log_res[$];
    logic         log_zero[$], log_carry[$], log_ill[$];

    always @(negedge clk) begin
        logic e0, e1, exp_v, pref_r1, z, c, ill;
        logic [W-1:0] r;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_rem  = 0;
            m_last = 1'b1;
            acc0   = 1'b0;
            acc1   = 1'b0;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            pref_r1 = ~m_last;
            if (!m_busy) begin
                if (!pref_r1) begin
                    if (r0_req_valid) e0 = 1'b1; else if (r1_req_valid) e1 = 1'b1;
                end else begin
                    if (r1_req_valid) e1 = 1'b1; else if (r0_req_valid) e0 = 1'b1;
                end
            end
            chk("r0_req_ready", r0_req_ready, e0);
            chk("r1_req_ready", r1_req_ready, e1);
            exp_v = m_busy && (m_rem == 0);
            chk("rsp_valid", rsp_valid, exp_v);
            chk("busy", busy, m_busy);
            if (exp_v) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", rsp_zero, m_zero);
                chk("rsp_carry", rsp_carry, m_carry);
                chk("rsp_illegal", rsp_illegal, m_ill);
            end
            if (m_busy && m_rem > 0) begin
                m_rem--;
            end else if (exp_v && rsp_ready) begin
                m_busy = 1'b0;
                m_last = m_id;
                log_id.push_back(m_id);
                log_res.push_back(m_res);
                log_zero.push_back(m_zero);
                log_carry.push_back(m_carry);
                log_ill.push_back(m_ill);
            end
            acc0 = r0_req_valid && r0_req_ready;
            acc1 = r1_req_valid && r1_req_ready;
            if (e0 || e1) begin
                if (e0) model_alu(r0_opcode, r0_a, r0_b, r, z, c, ill);
                else    model_alu(r1_opcode, r1_a, r1_b, r, z, c, ill);
                m_id    = e1;
                m_res   = r;
                m_zero  = z;
                m_carry = (r0_opcode == 6'b100000 && e0) || (r1_opcode == 6'b100000 && e1) ? c : 1'b0;
                m_ill   = ill;
                m_busy  = 1'b1;
                m_rem   = ill ? 0 : HOLD;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) r0_req_valid = 1'b0;
        if (acc1) r1_req_valid = 1'b0;
    endtask

    task automatic set_r(input int r, input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (r == 0) begin
            r0_opcode = op; r0_a = a; r0_b = b; r0_req_valid = 1'b1;
        end else begin
            r1_opcode = op; r1_a = a; r1_b = b; r1_req_valid = 1'b1;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((r0_req_valid || r1_req_valid || m_busy) && n < budget) begin
            step();
            n++;
        end
        chk("quiet_in_budget", 64'(n < budget), 1);
    endtask

    task automatic rand_req(input int r);
        logic [5:0] legal [8];
        logic [5:0] bad [4];
        logic [5:0] op;
        logic [W-1:0] a, b;
        legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b100110, 6'b000011, 6'b000010, 6'b100111};
        bad   = '{6'b001000, 6'b111111, 6'b000000, 6'b100001};
        op = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 3)] : legal[$urandom_range(0, 7)];
        a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
        if (op == 6'b000011 || op == 6'b000010) b = W'($urandom_range(0, 31));
        set_r(r, op, a, b);
    endtask

    initial begin
        int base, n0, n1, guard;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", rsp_result, 0);
        chk("reset_drive_op", dut.op_q, 6'h3F);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rsp_ready = 1'b1;

        base = log_id.size();
        set_r(0, 6'b100000, 32'd5, 32'd7);
        wait_quiet(20);
        chk("add_res", log_res[base], 12);
        chk("add_id", log_id[base], 0);
        chk("add_ill", log_ill[base], 0);

        set_r(1, 6'b100010, 32'd9, 32'd9);
        wait_quiet(20);
        set_r(1, 6'b000011, 32'h8000_0000, 32'd4);
        wait_quiet(20);
        chk("sub_zero", log_zero[base+1], 1);
        chk("sub_id", log_id[base+1], 1);
        chk("sra_res", log_res[base+2], 32'hF800_0000);

        base = log_id.size();
        n0 = 0; n1 = 0; guard = 0;
        while ((n0 < 2 || n1 < 2 || r0_req_valid || r1_req_valid) && guard < 60) begin
            if (!r0_req_valid && n0 < 2) begin set_r(0, 6'b100110, 32'h1234, 32'h00FF); n0++; end
            if (!r1_req_valid && n1 < 2) begin
                if (n1 == 0) set_r(1, 6'b100100, 32'hF0F0, 32'h0FF0);
                else         set_r(1, 6'b100100, 32'hFFFF, 32'h00FF);
                n1++;
            end
            step();
            guard++;
        end
        wait_quiet(20);
        chk("alt_id0", log_id[base], 0);
        chk("alt_id1", log_id[base+1], 1);
        chk("alt_id2", log_id[base+2], 0);
        chk("alt_id3", log_id[base+3], 1);
        chk("and2_res", log_res[base+3], 32'h00FF);

        base = log_id.size();
        set_r(0, 6'b001000, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("illegal_drive_nop", dut.op_q, 6'h3F);
            step();
        end
        wait_quiet(20);
        chk("illegal_flag", log_ill[base], 1);
        chk("illegal_res", log_res[base], 0);

        rsp_ready = 1'b0;
        set_r(0, 6'b100101, 32'hA0, 32'h05);
        guard = 0;
        while (r0_req_valid && guard < 20) begin step(); guard++; end
        set_r(1, 6'b100000, 32'hFFFF_FFFF, 32'd1);
        repeat (5 + HOLD) step();
        rsp_ready = 1'b1;
        wait_quiet(30);

        set_r(0, 6'b100000, 32'd3, 32'd4);
        guard = 0;
        while (r0_req_valid && guard < 20) begin step(); guard++; end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", rsp_valid, 0);
        step();
        base = log_id.size();
        set_r(1, 6'b100000, 32'd1, 32'd1);
        set_r(0, 6'b100010, 32'd8, 32'd3);
        wait_quiet(30);
        chk("rst_ptr_first_id", log_id[base], 0);
        chk("rst_r1_id", log_id[base+1], 1);
        chk("rst_r1_res", log_res[base+1], 2);

        for (int i = 0; i < 3000; i++) begin
            if (!r0_req_valid && $urandom_range(0, 2) == 0) rand_req(0);
            if (!r1_req_valid && $urandom_range(0, 2) == 0) rand_req(1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready = 1'b1;
        wait_quiet(50);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
